intc_cpu_responder: RTL and testbench
=====================================

Name: intc_cpu_responder

Overview:
- CPU-side responder for the interrupt controller's IRQ / isr_addr / IACK interface. It is the end that takes interrupts, not the end that raises them.
- Waits for an instruction boundary, then does three things:
  - saves the return PC into EPC;
  - redirects the PC to the ISR address supplied by the controller;
  - pulses IACK back to the controller.
- Tracks the in-ISR condition and redirects back to EPC on ERET.
- Sits between intc_top and the MIPS PC-select logic.

Parameters:
- ADDR_WIDTH, 32, width of PC, ISR address and EPC.
- IACK_CYCLES, 1, number of clock cycles IACK is held high per acknowledge (must be >= 1).
- IRQ_DROP_TIMEOUT, 8, cycles after IACK falls within which IRQ must be seen low at least once.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. Asynchronous, active-low.
- IRQ  input  1  interrupt request from the controller, level.
- isr_addr  input  ADDR_WIDTH  ISR entry address from the controller. Valid while IRQ=1.
- int_en  input  1  global interrupt enable from the CPU status register.
- instr_boundary  input  1  CPU is at an instruction boundary this cycle; pc_next is valid.
- pc_next  input  ADDR_WIDTH  address of the next instruction to execute (the return address).
- eret  input  1  return-from-interrupt instruction executing, single-cycle pulse.
- IACK  output  1  interrupt acknowledge to the controller.
- pc_sel  output  1  one-cycle PC redirect strobe.
- pc_target  output  ADDR_WIDTH  redirect target. Valid when pc_sel=1; holds its value otherwise.
- epc  output  ADDR_WIDTH  saved return address.
- in_isr  output  1  handler active; no nesting allowed.
- error  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. IACK=0, pc_sel=0, pc_target=0, epc=0, in_isr=0, error=0, all counters 0. A reset mid-operation aborts immediately; IACK drops without waiting for a clock edge.
- All outputs are registered.
- States: IDLE, ACK, SERVICE, RETURN.
- IDLE:
  - Take condition: IRQ=1, int_en=1 and instr_boundary=1 at a rising edge. If any of the three is 0, stay in IDLE.
  - On that edge (edge T): epc<=pc_next, pc_target<=isr_addr, pc_sel<=1, IACK<=1, in_isr<=1; go to ACK.
  - Latency: IACK, pc_sel and the new pc_target are visible 1 cycle after the sampling edge.
- ACK:
  - pc_sel is high for exactly one cycle.
  - IACK is high for exactly IACK_CYCLES cycles, then drops to 0; go to SERVICE.
  - Start the drop-timeout counter at 0 when IACK falls.
  - eret in ACK is ignored.
- SERVICE:
  - in_isr=1. IRQ is ignored for take purposes (no nesting).
  - Drop timeout: increment the counter each cycle until IRQ is sampled 0 at least once. If the count reaches IRQ_DROP_TIMEOUT before that, set error=1 (sticky until reset). Operation continues normally after the error.
  - On eret=1: pc_target<=epc, pc_sel<=1 (one cycle), go to RETURN.
- RETURN:
  - Lasts one cycle. in_isr<=0; go to IDLE.
  - IRQ is not sampled in RETURN, so the back-redirect always lands before a new take.
- Simultaneous events:
  - eret together with IRQ in SERVICE: eret wins. A still-pending IRQ is taken from IDLE at the earliest qualifying edge, i.e. no earlier than 2 cycles after eret.
  - eret in IDLE: ignored; no pc_sel.
  - IRQ=1 while int_en=0: stays pending, with no IACK and no redirect, until int_en rises at an instruction boundary.
- Width rules: epc and pc_target are ADDR_WIDTH wide and copied verbatim. No alignment checks, no arithmetic on them.
- Counters: the IACK counter is sized for IACK_CYCLES; the timeout counter saturates at IRQ_DROP_TIMEOUT (no wrap).

Test Plan:
- Basic take: reset, then IRQ=1, isr_addr=0x0000000D, int_en=1, instr_boundary=1, pc_next=0x00000040.
  - Next cycle: IACK=1, pc_sel=1, pc_target=0x0000000D, epc=0x00000040, in_isr=1.
  - One cycle later: pc_sel=0, IACK=0.
- Boundary and enable gating:
  - IRQ=1 with instr_boundary=0 for 3 cycles: IACK stays 0, pc_sel stays 0.
  - IRQ=1 with int_en=0: no take.
  - Raise both qualifiers: take occurs 1 cycle later.
- Return path: in SERVICE, drop IRQ, pulse eret.
  - Next cycle: pc_sel=1, pc_target=0x00000040.
  - Following cycle: in_isr=0, state IDLE.
  - error stays 0.
- No nesting plus eret priority:
  - In SERVICE, assert IRQ again with isr_addr=0x0000000B: no IACK.
  - Pulse eret while IRQ=1: return redirect to EPC first.
  - Second take with pc_target=0x0000000B no earlier than 2 cycles after eret.
- Drop timeout: hold IRQ=1 after IACK falls for 8 cycles (IRQ_DROP_TIMEOUT=8).
  - error=1 and stays 1 through the next take.
  - Cleared only by rst=0.
- Async reset mid-ACK: with IACK_CYCLES=3, assert rst=0 during the second IACK cycle.
  - IACK, in_isr and epc go to 0 immediately, without waiting for clk.
  - After release, a new take behaves like the basic take.

Source files
------------

// File: rtl/intc_cpu_responder.sv
// CPU-side interrupt responder: takes IRQ at an instruction boundary, saves EPC,
// redirects the PC to the ISR, pulses IACK, and redirects back to EPC on ERET.
module intc_cpu_responder #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned IACK_CYCLES      = 1,
    parameter int unsigned IRQ_DROP_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IRQ,
    input  logic [ADDR_WIDTH-1:0] isr_addr,
    input  logic                  int_en,
    input  logic                  instr_boundary,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  eret,
    output logic                  IACK,
    output logic                  pc_sel,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  in_isr,
    output logic                  error
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam logic [1:0] ST_RETURN  = 2'd3;

    localparam int unsigned ACK_W = $clog2(IACK_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(IRQ_DROP_TIMEOUT + 1);

    localparam logic [ACK_W-1:0] ACK_ONE  = ACK_W'(1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(IACK_CYCLES);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IRQ_DROP_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_PRE   = TO_W'(IRQ_DROP_TIMEOUT - 1);

    logic [1:0]       state;
    logic [ACK_W-1:0] ack_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             irq_dropped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            ack_cnt     <= '0;
            to_cnt      <= '0;
            irq_dropped <= 1'b0;
            IACK        <= 1'b0;
            pc_sel      <= 1'b0;
            pc_target   <= '0;
            epc         <= '0;
            in_isr      <= 1'b0;
            error       <= 1'b0;
        end else begin
            pc_sel <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (IRQ && int_en && instr_boundary) begin
                        epc       <= pc_next;
                        pc_target <= isr_addr;
                        pc_sel    <= 1'b1;
                        IACK      <= 1'b1;
                        in_isr    <= 1'b1;
                        ack_cnt   <= ACK_ONE;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // ack_cnt counts IACK-high cycles already elapsed, including the current one
                    if (ack_cnt == ACK_LAST) begin
                        IACK        <= 1'b0;
                        to_cnt      <= '0;
                        irq_dropped <= 1'b0;
                        state       <= ST_SERVICE;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_ONE;
                    end
                end
                ST_SERVICE: begin
                    if (!irq_dropped) begin
                        if (!IRQ) begin
                            irq_dropped <= 1'b1;
                        end else if (to_cnt != TO_LAST) begin
                            to_cnt <= to_cnt + TO_ONE;
                            if (to_cnt == TO_PRE) error <= 1'b1;
                        end
                    end
                    if (eret) begin
                        pc_target <= epc;
                        pc_sel    <= 1'b1;
                        state     <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    in_isr <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_cpu_responder.sv
// Bench for intc_cpu_responder: two instances (IACK_CYCLES 1 and 3) share stimulus
// and are compared every cycle against a behavioural model, plus directed spot checks.
module tb_intc_cpu_responder;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          irq;
    logic [AW-1:0] isr_addr;
    logic          int_en;
    logic          bnd;
    logic [AW-1:0] pc_next;
    logic          eret;

    logic          iack1, pc_sel1, in_isr1, err1;
    logic [AW-1:0] tgt1, epc1;
    logic          iack3, pc_sel3, in_isr3, err3;
    logic [AW-1:0] tgt3, epc3;

    int checks   = 0;
    int failures = 0;

    // model state, index 0 = IACK_CYCLES 1, index 1 = IACK_CYCLES 3
    int            ack_left [2];
    bit            serving  [2];
    bit            returning[2];
    bit            dropped  [2];
    int            high_cnt [2];
    logic          m_iack   [2];
    logic          m_pc_sel [2];
    logic          m_in_isr [2];
    logic          m_err    [2];
    logic [AW-1:0] m_tgt    [2];
    logic [AW-1:0] m_epc    [2];

    intc_cpu_responder #(.ADDR_WIDTH(AW), .IACK_CYCLES(1), .IRQ_DROP_TIMEOUT(TO)) u_dut1 (
        .clk(clk), .rst(rst_n), .IRQ(irq), .isr_addr(isr_addr), .int_en(int_en),
        .instr_boundary(bnd), .pc_next(pc_next), .eret(eret),
        .IACK(iack1), .pc_sel(pc_sel1), .pc_target(tgt1), .epc(epc1),
        .in_isr(in_isr1), .error(err1)
    );

    intc_cpu_responder #(.ADDR_WIDTH(AW), .IACK_CYCLES(3), .IRQ_DROP_TIMEOUT(TO)) u_dut3 (
        .clk(clk), .rst(rst_n), .IRQ(irq), .isr_addr(isr_addr), .int_en(int_en),
        .instr_boundary(bnd), .pc_next(pc_next), .eret(eret),
        .IACK(iack3), .pc_sel(pc_sel3), .pc_target(tgt3), .epc(epc3),
        .in_isr(in_isr3), .error(err3)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ack_left[k] = 0; serving[k] = 0; returning[k] = 0; dropped[k] = 0;
            high_cnt[k] = 0; m_iack[k] = 0; m_pc_sel[k] = 0; m_in_isr[k] = 0;
            m_err[k] = 0; m_tgt[k] = '0; m_epc[k] = '0;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            m_pc_sel[k] = 0;
            if (returning[k]) begin
                returning[k] = 0;
                m_in_isr[k]  = 0;
            end else if (ack_left[k] > 0) begin
                ack_left[k]--;
                if (ack_left[k] == 0) begin
                    m_iack[k] = 0; serving[k] = 1; high_cnt[k] = 0; dropped[k] = 0;
                end
            end else if (serving[k]) begin
                if (!dropped[k]) begin
                    if (!irq) dropped[k] = 1;
                    else if (high_cnt[k] < TO) begin
                        high_cnt[k]++;
                        if (high_cnt[k] == TO) m_err[k] = 1;
                    end
                end
                if (eret) begin
                    m_tgt[k] = m_epc[k]; m_pc_sel[k] = 1; serving[k] = 0; returning[k] = 1;
                end
            end else if (irq && int_en && bnd) begin
                m_epc[k] = pc_next; m_tgt[k] = isr_addr; m_pc_sel[k] = 1;
                m_iack[k] = 1; m_in_isr[k] = 1; ack_left[k] = (k == 0) ? 1 : 3;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic iack, input logic psel,
                             input logic [AW-1:0] tgt, input logic [AW-1:0] ep,
                             input logic isr, input logic err);
        chk($sformatf("d%0d_iack", k), iack, m_iack[k]);
        chk($sformatf("d%0d_pc_sel", k), psel, m_pc_sel[k]);
        chk($sformatf("d%0d_pc_target", k), tgt, m_tgt[k]);
        chk($sformatf("d%0d_epc", k), ep, m_epc[k]);
        chk($sformatf("d%0d_in_isr", k), isr, m_in_isr[k]);
        chk($sformatf("d%0d_error", k), err, m_err[k]);
    endtask

    task automatic check_all();
        check_dut(0, iack1, pc_sel1, tgt1, epc1, in_isr1, err1);
        check_dut(1, iack3, pc_sel3, tgt3, epc3, in_isr3, err3);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; irq = 1'b0; isr_addr = '0; int_en = 1'b0; bnd = 1'b0;
        pc_next = '0; eret = 1'b0;
        model_reset();
        repeat (2) cycle();
        chk("rst_iack", iack1, 1'b0);
        chk("rst_pc_sel", pc_sel1, 1'b0);
        chk("rst_pc_target", tgt1, 32'h0);
        chk("rst_epc", epc1, 32'h0);
        chk("rst_in_isr", in_isr1, 1'b0);
        chk("rst_error", err1, 1'b0);
        rst_n = 1'b1;
        cycle();

        // basic take
        irq = 1'b1; isr_addr = 32'h0000000D; int_en = 1'b1; bnd = 1'b1; pc_next = 32'h00000040;
        cycle();
        chk("take_iack", iack1, 1'b1);
        chk("take_pc_sel", pc_sel1, 1'b1);
        chk("take_target", tgt1, 32'h0000000D);
        chk("take_epc", epc1, 32'h00000040);
        chk("take_in_isr", in_isr1, 1'b1);
        irq = 1'b0; bnd = 1'b0;
        cycle();
        chk("take_pc_sel_drop", pc_sel1, 1'b0);
        chk("take_iack_drop", iack1, 1'b0);
        chk("take3_iack_held", iack3, 1'b1);
        repeat (2) cycle();

        // return path
        eret = 1'b1;
        cycle();
        chk("ret_pc_sel", pc_sel1, 1'b1);
        chk("ret_target", tgt1, 32'h00000040);
        chk("ret3_target", tgt3, 32'h00000040);
        eret = 1'b0;
        cycle();
        chk("ret_in_isr", in_isr1, 1'b0);
        chk("ret_error", err1, 1'b0);

        // boundary and enable gating
        irq = 1'b1; isr_addr = 32'h00000022; bnd = 1'b0; int_en = 1'b1;
        repeat (3) begin
            cycle();
            chk("gate_bnd_iack", iack1, 1'b0);
            chk("gate_bnd_pc_sel", pc_sel1, 1'b0);
        end
        bnd = 1'b1; int_en = 1'b0;
        repeat (2) begin
            cycle();
            chk("gate_en_iack", iack1, 1'b0);
        end
        pc_next = 32'h00000080; int_en = 1'b1;
        cycle();
        chk("gate_take_iack", iack1, 1'b1);
        chk("gate_take_target", tgt1, 32'h00000022);
        chk("gate_take_epc", epc1, 32'h00000080);
        irq = 1'b0; bnd = 1'b0;
        repeat (3) cycle();

        // no nesting, eret priority over pending IRQ
        irq = 1'b1; isr_addr = 32'h0000000B; bnd = 1'b1;
        repeat (2) begin
            cycle();
            chk("nest_iack", iack1, 1'b0);
            chk("nest3_iack", iack3, 1'b0);
            chk("nest_pc_sel", pc_sel1, 1'b0);
        end
        eret = 1'b1;
        cycle();
        chk("prio_pc_sel", pc_sel1, 1'b1);
        chk("prio_target", tgt1, 32'h00000080);
        chk("prio_iack", iack1, 1'b0);
        eret = 1'b0;
        cycle();
        chk("prio_ret_iack", iack1, 1'b0);
        chk("prio_ret_in_isr", in_isr1, 1'b0);
        pc_next = 32'h00000100;
        cycle();
        chk("second_take_iack", iack1, 1'b1);
        chk("second_take_target", tgt1, 32'h0000000B);
        chk("second_take_epc", epc1, 32'h00000100);

        // drop timeout: IRQ held high after IACK falls
        bnd = 1'b0;
        repeat (12) cycle();
        chk("timeout_error", err1, 1'b1);
        chk("timeout3_error", err3, 1'b1);
        irq = 1'b0;
        cycle();
        eret = 1'b1;
        cycle();
        eret = 1'b0;
        cycle();
        irq = 1'b1; isr_addr = 32'h00000033; bnd = 1'b1;
        cycle();
        chk("sticky_take_iack", iack1, 1'b1);
        chk("sticky_error", err1, 1'b1);
        irq = 1'b0; bnd = 1'b0;
        repeat (4) cycle();
        eret = 1'b1;
        cycle();
        eret = 1'b0;
        repeat (2) cycle();

        // asynchronous reset during the second IACK cycle of the 3-cycle instance
        irq = 1'b1; isr_addr = 32'h0000000D; bnd = 1'b1; pc_next = 32'h00000040;
        cycle();
        irq = 1'b0; bnd = 1'b0;
        cycle();
        chk("async_pre_iack3", iack3, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_iack3", iack3, 1'b0);
        chk("async_in_isr3", in_isr3, 1'b0);
        chk("async_epc3", epc3, 32'h0);
        chk("async_error_clear", err1, 1'b0);
        chk("async_error3_clear", err3, 1'b0);
        cycle();
        rst_n = 1'b1;
        irq = 1'b1; bnd = 1'b1;
        cycle();
        chk("post_rst_iack3", iack3, 1'b1);
        chk("post_rst_pc_sel3", pc_sel3, 1'b1);
        chk("post_rst_target3", tgt3, 32'h0000000D);
        chk("post_rst_epc3", epc3, 32'h00000040);
        irq = 1'b0; bnd = 1'b0;
        repeat (4) cycle();
        eret = 1'b1;
        cycle();
        eret = 1'b0;
        repeat (2) cycle();

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) irq = ~irq;
            isr_addr = $urandom();
            pc_next  = $urandom();
            int_en   = ($urandom_range(0, 7) != 0);
            bnd      = $urandom_range(0, 1) == 1;
            eret     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
